// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared FSM state encoding for clock_monitor
package clock_monitor_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } cm_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer + history FF; clk/rst in, din async in, rise/fall one-cycle strobes out
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, hist;
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, hist} <= '0;
    else {s1, s2, hist} <= {din, s1, s2};
  end
  assign rise = s2 & ~hist;
  assign fall = ~s2 & hist;
endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures async mon_clk in clk_in domain; outputs rise/fall strobes, period+period_valid, locked and lost levels
module clock_monitor import clock_monitor_pkg::*; #(
  parameter int EXPECTED_PERIOD = 26,
  parameter int TOLERANCE       = 2,
  parameter int LOCK_COUNT      = 4,
  parameter int TIMEOUT         = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             mon_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  if (TOLERANCE >= EXPECTED_PERIOD || TIMEOUT <= EXPECTED_PERIOD + TOLERANCE) begin : g_bad_params
    $error("clock_monitor: need TOLERANCE < EXPECTED_PERIOD and TIMEOUT > EXPECTED_PERIOD + TOLERANCE");
  end
  cm_state_t state, state_n;
  logic rise, fall, in_win, timeout, measuring, good_hit;
  logic [CNT_W-1:0] cnt, gap;
  logic [GW-1:0] good;
  sync_edge_detect u_sync (
    .clk  (clk_in),
    .rst  (rst),
    .din  (mon_clk),
    .rise (rise),
    .fall (fall)
  );
  always_comb begin
    measuring = state == MEASURE || state == LOCKED;
    in_win    = cnt >= LO && cnt <= HI && ~&cnt;
    // timeout fires on the cycle the gap would reach TIMEOUT; any edge that cycle wins
    timeout   = !(rise || fall) && gap == TMO - 1'b1;
    good_hit  = good + 1'b1 == GW'(LOCK_COUNT);
    state_n   = rise ? ((measuring && in_win && (state == LOCKED || good_hit)) ? LOCKED : MEASURE)
              : (timeout && measuring) ? LOST : state;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      good         <= '0;
      cnt          <= '0;
      gap          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      state        <= state_n;
      good         <= (rise && state == MEASURE && in_win) ? good + 1'b1 : rise ? '0 : good;
      cnt          <= rise ? CNT_W'(1) : &cnt ? cnt : cnt + 1'b1;
      gap          <= (rise || fall) ? '0 : gap == TMO ? gap : gap + 1'b1;
      period       <= (rise && measuring) ? cnt : period;
      period_valid <= rise && measuring;
      rise_pulse   <= rise;
      fall_pulse   <= fall;
      // locked lags lock entry by a cycle but drops together with the leaving transition
      locked       <= state == LOCKED && state_n == LOCKED;
      lost         <= state_n == LOST;
    end
  end
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: randomized scoreboard bench for clock_monitor
`timescale 1ns/1ps
module tb_clock_monitor;
  import clock_monitor_pkg::*;
  localparam int EP = 26, TOL = 2, LC = 4, TMO = 64;
  logic clk_in = 1'b0, rst = 1'b1, mon_clk = 1'b0;
  logic rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [15:0] period;
  clock_monitor dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .mon_clk      (mon_clk),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;
  typedef struct { int cyc; logic valid; int per; } rise_t;
  typedef struct { int cyc; logic lk; logic ls; cm_state_t st; logic chk_rst; } lvl_t;
  rise_t rq[$];
  int    fq[$];
  lvl_t  lq[$];
  int checks = 0, errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  rise_t re;
  lvl_t  le;
  always @(negedge clk_in) begin
    if (rq.size() > 0 && rq[0].cyc < cyc) begin
      re = rq.pop_front();
      chk("rise_missing", cyc, re.cyc);
    end
    if (fq.size() > 0 && fq[0] < cyc) chk("fall_missing", cyc, fq.pop_front());
    if (rise_pulse) begin
      if (rq.size() == 0) chk("rise_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rise_cyc", cyc, re.cyc);
        chk("period_valid", int'(period_valid), int'(re.valid));
        if (re.valid) chk("period", int'(period), re.per);
      end
    end else if (period_valid) chk("valid_without_rise", 1, 0);
    if (fall_pulse) begin
      if (fq.size() == 0) chk("fall_unexpected", 1, 0);
      else chk("fall_cyc", cyc, fq.pop_front());
    end
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      le = lq.pop_front();
      chk("level_cyc", cyc, le.cyc);
      chk("locked", int'(locked), int'(le.lk));
      chk("lost", int'(lost), int'(le.ls));
      chk("state", int'(dut.state), int'(le.st));
      if (le.chk_rst) begin
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_rise", int'(rise_pulse), 0);
        chk("rst_fall", int'(fall_pulse), 0);
      end
    end
  end
  cm_state_t st = IDLE;
  int good = 0, last_tog = 0, last_rise = 0;
  task automatic half(int len, int rst_off = -1);
    bit valid, inw;
    int per;
    if (rst_off < 0 && len > TMO && (st == MEASURE || st == LOCKED)) begin
      lq.push_back('{last_tog + 66, st == LOCKED, 1'b0, st, 1'b0});
      lq.push_back('{last_tog + 67, 1'b0, 1'b1, LOST, 1'b0});
      st = LOST;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk_in);
      rst = (i == rst_off);
      if (i == rst_off) begin
        lq.push_back('{cyc + 1, 1'b0, 1'b0, IDLE, 1'b1});
        st = IDLE;
        good = 0;
      end
    end
    mon_clk = ~mon_clk;
    last_tog = cyc;
    if (mon_clk) begin
      valid = st == MEASURE || st == LOCKED;
      per = cyc - last_rise;
      inw = per >= EP - TOL && per <= EP + TOL;
      rq.push_back('{cyc + 3, valid, per});
      if (!valid || !inw) begin
        st = MEASURE;
        good = 0;
      end else if (st == MEASURE) begin
        good++;
        if (good == LC) st = LOCKED;
      end
      lq.push_back('{cyc + 4, st == LOCKED, 1'b0, st, 1'b0});
      last_rise = cyc;
    end else fq.push_back(cyc + 3);
  endtask
  task automatic per_cyc(int p, int h = -1);
    int hh;
    hh = h < 0 ? p / 2 : h;
    half(hh);
    half(p - hh);
  endtask
  initial begin
    int p;
    @(negedge clk_in);
    lq.push_back('{cyc + 1, 1'b0, 1'b0, IDLE, 1'b1});
    @(negedge clk_in);
    rst = 1'b0;
    last_tog = cyc;
    half(80);
    repeat (4) per_cyc(26);
    per_cyc(29);
    per_cyc(24);
    per_cyc(28);
    per_cyc(28);
    per_cyc(24);
    per_cyc(29);
    per_cyc(23);
    repeat (4) per_cyc(26);
    per_cyc(113, 100);
    repeat (4) per_cyc(26);
    per_cyc(77, 13);
    repeat (4) per_cyc(26);
    per_cyc(78, 13);
    repeat (4) per_cyc(26);
    repeat (40) begin
      p = $urandom_range(9, 0) == 0 ? int'($urandom_range(140, 60)) : int'($urandom_range(32, 20));
      per_cyc(p, int'($urandom_range(p - 6, 6)));
    end
    repeat (4) per_cyc(26);
    half(13);
    half(20, 8);
    repeat (3) per_cyc(26);
    repeat (10) @(negedge clk_in);
    chk("rise_queue_empty", rq.size(), 0);
    chk("fall_queue_empty", fq.size(), 0);
    chk("level_queue_empty", lq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #600000;
    $display("FAIL watchdog at cyc %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
